// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage MIPS pipeline
// Memory-wait FSM with timeout into HALT, plus saturating stall/redirect counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_write_reg,
  input  logic             exmem_branch_eq,
  input  logic             exmem_branch_ne,
  input  logic             exmem_zero,
  input  logic             exmem_jump,
  input  logic             exmem_jr,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_req,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q;
  logic       access, taken, load_use;
  logic       freeze, normal, stall_evt, flush_evt;

  assign access   = exmem_memread | exmem_memwrite;
  assign taken    = (exmem_branch_eq & exmem_zero) | (exmem_branch_ne & ~exmem_zero) |
                    exmem_jump | exmem_jr;
  assign load_use = idex_memread && (idex_write_reg != 5'd0) &&
                    ((idex_write_reg == id_rs) || (id_uses_rt && (idex_write_reg == id_rt)));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    normal  = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      RUN: begin
        mem_req = access;
        if (access && !mem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else begin
          normal = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          normal  = 1'b1;
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == TIMEOUT) begin
          freeze  = 1'b1;
          state_d = HALT;
        end else begin
          freeze = 1'b1;
          wait_d = wait_q + 8'd1;
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
    if (!reset) begin
      freeze  = 1'b0;
      normal  = 1'b0;
      mem_req = 1'b0;
    end
  end

  // Memory freeze outranks redirect and load-use; the redirect waits for mem_ready.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (freeze) begin
      memwb_flush = 1'b1;
    end else if (normal) begin
      if (taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        idex_flush  = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
      end
    end
  end

  assign stall_evt = freeze | (normal & ~taken & load_use);
  assign flush_evt = normal & taken;
  assign mem_error = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      err_q       <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == HALT) err_q <= 1'b1;
      if (stall_evt && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
      if (flush_evt && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench for pipeline_hazard_ctrl
// Default instance for hazards/counters; small instance (timeout 4, 2-bit counters) for HALT and saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs, id_rt, idex_write_reg;
  logic id_uses_rt, idex_memread;
  logic exmem_branch_eq, exmem_branch_ne, exmem_zero, exmem_jump, exmem_jr;
  logic exmem_memread, exmem_memwrite, mem_ready;

  logic pc_write, ifid_write, idex_write, exmem_write;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_req, mem_error;
  logic [15:0] stall_count, flush_count;

  logic s_pc_write, s_ifid_write, s_idex_write, s_exmem_write;
  logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_mem_req, s_mem_error;
  logic [1:0] s_stall_count, s_flush_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
    .exmem_branch_eq(exmem_branch_eq), .exmem_branch_ne(exmem_branch_ne),
    .exmem_zero(exmem_zero), .exmem_jump(exmem_jump), .exmem_jr(exmem_jr),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mem_req(mem_req),
    .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
    .exmem_branch_eq(exmem_branch_eq), .exmem_branch_ne(exmem_branch_ne),
    .exmem_zero(exmem_zero), .exmem_jump(exmem_jump), .exmem_jr(exmem_jr),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_write(s_idex_write),
    .exmem_write(s_exmem_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .mem_req(s_mem_req),
    .mem_error(s_mem_error), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; idex_memread = 1'b0; idex_write_reg = 5'd0;
    exmem_branch_eq = 1'b0; exmem_branch_ne = 1'b0; exmem_zero = 1'b0;
    exmem_jump = 1'b0; exmem_jr = 1'b0; exmem_memread = 1'b0; exmem_memwrite = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Asynchronous pulse between edges; tasks run from posedge+1 onwards.
  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b0000) begin n_fail++; $display("FAIL reset_enables got %b want 0000", {pc_write, ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_req} !== 5'b0) begin n_fail++; $display("FAIL reset_flush_req got %b want 00000", {ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_req}); end
    n_cmp++; if ({mem_error, stall_count, flush_count} !== 33'd0) begin n_fail++; $display("FAIL reset_regs err=%b stall=%0d flush=%0d want 0", mem_error, stall_count, flush_count); end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b1111) begin n_fail++; $display("FAIL idle_advance got %b want 1111", {pc_write, ifid_write, idex_write, exmem_write}); end
    next_cycle();
  endtask

  task automatic test_load_use();
    pulse_reset();
    idex_memread = 1'b1; idex_write_reg = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b0011) begin n_fail++; $display("FAIL lu_rs_enables got %b want 0011", {pc_write, ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({ifid_flush, idex_flush, exmem_flush, memwb_flush} !== 4'b0100) begin n_fail++; $display("FAIL lu_rs_flush got %b want 0100", {ifid_flush, idex_flush, exmem_flush, memwb_flush}); end
    next_cycle();
    n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_stall_count got %0d want 1", stall_count); end
    idex_write_reg = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    n_cmp++; if ({pc_write, idex_flush} !== 2'b10) begin n_fail++; $display("FAIL lu_r0 got pc=%b idf=%b want 1 0", pc_write, idex_flush); end
    next_cycle();
    n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_r0_count got %0d want 1", stall_count); end
    idex_write_reg = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_write, idex_flush} !== 2'b01) begin n_fail++; $display("FAIL lu_rt got pc=%b idf=%b want 0 1", pc_write, idex_flush); end
    next_cycle();
    id_uses_rt = 1'b0;
    @(negedge clk);
    n_cmp++; if ({pc_write, idex_flush} !== 2'b10) begin n_fail++; $display("FAIL lu_rt_unused got pc=%b idf=%b want 1 0", pc_write, idex_flush); end
    next_cycle();
    n_cmp++; if (stall_count !== 16'd2) begin n_fail++; $display("FAIL lu_rt_count got %0d want 2", stall_count); end
  endtask

  task automatic test_branch();
    pulse_reset();
    exmem_branch_ne = 1'b1; exmem_zero = 1'b0;
    idex_memread = 1'b1; idex_write_reg = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_write, idex_write, exmem_write} !== 4'b1111) begin n_fail++; $display("FAIL bne_enables got %b want 1111", {pc_write, ifid_write, idex_write, exmem_write}); end
    n_cmp++; if ({ifid_flush, idex_flush, exmem_flush, memwb_flush} !== 4'b1110) begin n_fail++; $display("FAIL bne_flush got %b want 1110", {ifid_flush, idex_flush, exmem_flush, memwb_flush}); end
    next_cycle();
    n_cmp++; if ({flush_count, stall_count} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL bne_counts flush=%0d stall=%0d want 1 0", flush_count, stall_count); end
    idle();
    exmem_branch_eq = 1'b1; exmem_zero = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ifid_flush, pc_write} !== 2'b01) begin n_fail++; $display("FAIL beq_not_taken got flush=%b pc=%b want 0 1", ifid_flush, pc_write); end
    next_cycle();
    idle();
    exmem_jr = 1'b1;
    @(negedge clk);
    n_cmp++; if (exmem_flush !== 1'b1) begin n_fail++; $display("FAIL jr_flush got %b want 1", exmem_flush); end
    next_cycle();
    n_cmp++; if (flush_count !== 16'd2) begin n_fail++; $display("FAIL jr_count got %0d want 2", flush_count); end
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    exmem_memread = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({mem_req, memwb_flush, pc_write, exmem_write, ifid_flush} !== 5'b11000) begin n_fail++; $display("FAIL wait_freeze%0d got %b want 11000", i, {mem_req, memwb_flush, pc_write, exmem_write, ifid_flush}); end
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_req, memwb_flush, pc_write, exmem_write} !== 4'b1011) begin n_fail++; $display("FAIL wait_release got %b want 1011", {mem_req, memwb_flush, pc_write, exmem_write}); end
    next_cycle();
    exmem_memread = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mem_req, pc_write} !== 2'b01) begin n_fail++; $display("FAIL wait_back_run got req=%b pc=%b want 0 1", mem_req, pc_write); end
    n_cmp++; if (stall_count !== 16'd3) begin n_fail++; $display("FAIL wait_stall_count got %0d want 3", stall_count); end
    next_cycle();
  endtask

  task automatic test_freeze_over_redirect();
    pulse_reset();
    exmem_memwrite = 1'b1; exmem_jump = 1'b1;
    idex_memread = 1'b1; idex_write_reg = 5'd4; id_rs = 5'd4;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_flush, idex_flush, memwb_flush} !== 4'b0001) begin n_fail++; $display("FAIL frz_redirect got %b want 0001", {pc_write, ifid_flush, idex_flush, memwb_flush}); end
    next_cycle();
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pc_write, ifid_flush, exmem_flush, memwb_flush} !== 4'b1110) begin n_fail++; $display("FAIL frz_release_taken got %b want 1110", {pc_write, ifid_flush, exmem_flush, memwb_flush}); end
    next_cycle();
    n_cmp++; if ({stall_count, flush_count} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL frz_counts stall=%0d flush=%0d want 1 1", stall_count, flush_count); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    exmem_memread = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({s_mem_req, s_memwb_flush, s_pc_write, s_mem_error} !== 4'b1100) begin n_fail++; $display("FAIL to_freeze%0d got %b want 1100", i, {s_mem_req, s_memwb_flush, s_pc_write, s_mem_error}); end
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if ({s_mem_error, s_mem_req, s_memwb_flush, s_pc_write, s_ifid_write, s_idex_write, s_exmem_write} !== 7'b1010000) begin n_fail++; $display("FAIL to_halt%0d got %b want 1010000", i, {s_mem_error, s_mem_req, s_memwb_flush, s_pc_write, s_ifid_write, s_idex_write, s_exmem_write}); end
      mem_ready = 1'b1;
      next_cycle();
    end
    reset = 1'b0;
    #1;
    n_cmp++; if ({s_mem_error, s_stall_count} !== 3'b000) begin n_fail++; $display("FAIL to_reset got err=%b stall=%0d want 0 0", s_mem_error, s_stall_count); end
    idle();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({s_pc_write, s_memwb_flush} !== 2'b10) begin n_fail++; $display("FAIL to_run_after_reset got pc=%b mwf=%b want 1 0", s_pc_write, s_memwb_flush); end
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    pulse_reset();
    idex_memread = 1'b1; idex_write_reg = 5'd12; id_rs = 5'd12;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      n_cmp++; if (s_stall_count !== exp_sat[i]) begin n_fail++; $display("FAIL sat%0d got %0d want %0d", i, s_stall_count, exp_sat[i]); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    exmem_memread = 1'b1; mem_ready = 1'b0;
    next_cycle();
    #2;
    n_cmp++; if ({mem_req, memwb_flush, stall_count} !== {2'b11, 16'd1}) begin n_fail++; $display("FAIL ar_pre got req=%b mwf=%b stall=%0d want 1 1 1", mem_req, memwb_flush, stall_count); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req, memwb_flush, pc_write, stall_count} !== {3'b000, 16'd0}) begin n_fail++; $display("FAIL ar_immediate got req=%b mwf=%b pc=%b stall=%0d want 0 0 0 0", mem_req, memwb_flush, pc_write, stall_count); end
    exmem_memread = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({mem_req, pc_write} !== 2'b01) begin n_fail++; $display("FAIL ar_run got req=%b pc=%b want 0 1", mem_req, pc_write); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_over_redirect();
    test_timeout();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Per cycle, drives write-enable and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sources: load-use hazards from ID/EX, control redirects resolved from EX/MEM fields, and the data-memory ready handshake.
- A small FSM tracks memory wait with timeout; saturating counters record stall and flush events for debug.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before entering HALT; legal range 1..255.
- CNT_W, 16: width of stall_count and flush_count.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of the instruction in IF/ID
- id_rt  in  5  rt field of the instruction in IF/ID
- id_uses_rt  in  1  instruction in IF/ID reads rt as a source
- idex_memread  in  1  MemRead in ID/EX
- idex_write_reg  in  5  destination register in ID/EX
- exmem_branch_eq  in  1  BranchEQ in EX/MEM
- exmem_branch_ne  in  1  BranchNE in EX/MEM
- exmem_zero  in  1  ALU zero in EX/MEM
- exmem_jump  in  1  Jump in EX/MEM
- exmem_jr  in  1  Jr in EX/MEM
- exmem_memread  in  1  MemRead in EX/MEM
- exmem_memwrite  in  1  MemWrite in EX/MEM
- mem_ready  in  1  data memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- exmem_write  out  1  EX/MEM load enable
- ifid_flush  out  1  load bubble into IF/ID
- idex_flush  out  1  load bubble into ID/EX
- exmem_flush  out  1  load bubble into EX/MEM
- memwb_flush  out  1  load bubble into MEM/WB
- mem_req  out  1  data-memory access request
- mem_error  out  1  sticky memory-timeout flag
- stall_count  out  CNT_W  saturating stall-cycle count
- flush_count  out  CNT_W  saturating redirect count

Behaviour:
- State is clk-registered, cleared asynchronously by reset==0. All enable/flush/mem_req outputs are combinational from state and inputs.
- While reset==0: every enable, flush and mem_req = 0; mem_error = 0; counters = 0; state = RUN; wait_cnt = 0.
- Derived signals:
  - access = exmem_memread | exmem_memwrite
  - taken = (branch_eq & zero) | (branch_ne & ~zero) | jump | jr
  - load_use = idex_memread & (idex_write_reg != 0) & ((idex_write_reg == id_rs) | (id_uses_rt & idex_write_reg == id_rt))
- FSM states: RUN, MEM_WAIT, HALT.
- RUN:
  - mem_req = access.
  - If access & ~mem_ready: freeze this cycle; go to MEM_WAIT; wait_cnt = 1.
- MEM_WAIT:
  - mem_req = 1.
  - If mem_ready: this cycle is a normal RUN cycle (priority rules below); go to RUN; wait_cnt = 0.
  - Else if wait_cnt == MEM_TIMEOUT: freeze; go to HALT; set mem_error.
  - Else: freeze; wait_cnt + 1.
- HALT: freeze every cycle; mem_req = 0; mem_error = 1. Exit only via reset.
- Freeze cycle:
  - pc_write = ifid_write = idex_write = exmem_write = 0.
  - ifid_flush = idex_flush = exmem_flush = 0.
  - memwb_flush = 1 (the stalled MEM instruction does not retire twice).
- Normal cycle, priority taken > load_use > advance:
  - taken: all four enables 1 (PC loads the target); ifid_flush = idex_flush = exmem_flush = 1; memwb_flush = 0. load_use is ignored.
  - load_use: pc_write = ifid_write = 0; idex_write = exmem_write = 1; idex_flush = 1; all other flushes 0.
  - advance: all enables 1, all flushes 0.
- A memory freeze overrides taken and load_use in the same cycle. The redirect applies on the cycle mem_ready is seen.
- Flush and write are both asserted on a register → the bubble wins.
- Counters:
  - stall_count +1 on each freeze or load_use cycle (HALT included).
  - flush_count +1 on each taken cycle.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Reset mid-MEM_WAIT or in HALT returns immediately to RUN and clears mem_error and the counters.

Test Plan:
- Load-use: idex_memread=1, idex_write_reg=8, id_rs=8 → pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1; stall_count goes 0→1. Same stimulus with idex_write_reg=0 → no stall.
- Branch taken: exmem_branch_ne=1, exmem_zero=0, plus a simultaneous load-use → ifid/idex/exmem_flush=1, pc_write=1; flush_count=1; stall_count unchanged.
- Memory wait: exmem_memread=1, mem_ready low for 3 cycles then high → 3 freeze cycles with memwb_flush=1 and mem_req=1 throughout. The 4th cycle advances and the state returns to RUN; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → HALT entered after the 5th freeze cycle; mem_error=1; mem_req=0; enables stay 0. Assert reset=0 → mem_error=0, state RUN.
- Saturation: CNT_W=2, 5 consecutive load-use cycles → stall_count reads 1,2,3,3,3.
- Async reset mid-MEM_WAIT: drop reset between clock edges → outputs clear immediately without waiting for a clock edge.
